// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router types and defaults
package noc_pkg;

  localparam int NOC_DATA_WIDTH = 8;
  localparam int NOC_STALL_MAX  = 16;

  typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } out_state_t;

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - synchronous fall-through FIFO with occupancy count
module noc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is shown combinationally so the consumer sees it the cycle after the write.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/block_output.sv
// rtl/block_output.sv - router output port: FIFO, val/ret handshake, stall and overflow supervision
module block_output
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int STALL_MAX  = NOC_STALL_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      Data_in,
  input  logic                       wr_en,
  output logic                       full,
  output logic [DATA_WIDTH-1:0]      Data_out,
  output logic                       val_out,
  input  logic                       ret_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stall_err,
  output logic                       ovf_err
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int SCW = $clog2(STALL_MAX+1);

  logic           push;
  logic           pop;
  logic           stalled;
  logic [SCW-1:0] stall_cnt;
  out_state_t     state;
  out_state_t     state_next;

  noc_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (Data_in),
    .push      (push),
    .pop       (pop),
    .head      (Data_out),
    .count     (count),
    .full      (full)
  );

  // full comes from registered count, so a same-cycle pop never relieves it.
  assign push    = wr_en && !full;
  assign val_out = (count != '0) && !ret_out;
  assign pop     = val_out;
  assign stalled = (count != '0) && ret_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (wr_en && full) begin
      ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (!stalled) begin
      stall_cnt <= '0;
    end else begin
      if (stall_cnt != SCW'(STALL_MAX)) begin
        stall_cnt <= stall_cnt + SCW'(1);
      end
      if (stall_cnt == SCW'(STALL_MAX - 1)) begin
        stall_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (push) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (pop && !push && (count == CW'(1))) begin
          state_next = IDLE;
        end else if (ret_out) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if (!ret_out) begin
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
